// File: rtl/prefix_scan_pkg.sv
// rtl/prefix_scan_pkg.sv - operator encoding and lane combine helper for the prefix scan pipe
package prefix_scan_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_OR   = 2'd1,
        OP_MAXU = 2'd2,
        OP_XOR  = 2'd3
    } scan_op_e;

    // Widest lane the combine helper handles; callers zero-extend into it and
    // truncate the result back to their own lane width.
    localparam int MAX_W = 64;

    // Identity element shared by every operator.
    localparam logic [MAX_W-1:0] IDENTITY = '0;

    // Zero-extended operands keep MAXU an unsigned compare, and truncating
    // the sum back to W bits gives the modulo-2^W wrap for ADD.
    function automatic logic [MAX_W-1:0] scan_combine(
        input scan_op_e          op,
        input logic [MAX_W-1:0]  a,
        input logic [MAX_W-1:0]  b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_OR:   return a | b;
            OP_MAXU: return (a > b) ? a : b;
            default: return a ^ b;
        endcase
    endfunction

endpackage

// File: rtl/prefix_scan_stage.sv
// rtl/prefix_scan_stage.sv - one registered Kogge-Stone combine level with hold enable
module prefix_scan_stage
    import prefix_scan_pkg::*;
#(
    parameter int LANES = 8,
    parameter int W     = 16,
    parameter int DIST  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [LANES*W-1:0] in_data,
    input  logic [1:0]         in_mode,
    input  logic               in_excl,
    input  logic               in_chain,
    output logic               out_valid,
    output logic [LANES*W-1:0] out_data,
    output logic [1:0]         out_mode,
    output logic               out_excl,
    output logic               out_chain
);

    logic [LANES*W-1:0] comb_data;

    // Lanes below DIST have no partner at this level and pass through.
    always_comb begin
        comb_data = in_data;
        for (int i = DIST; i < LANES; i++) begin
            comb_data[i*W +: W] = W'(scan_combine(scan_op_e'(in_mode),
                                                  MAX_W'(in_data[i*W +: W]),
                                                  MAX_W'(in_data[(i-DIST)*W +: W])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            out_excl  <= 1'b0;
            out_chain <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= comb_data;
            out_mode  <= in_mode;
            out_excl  <= in_excl;
            out_chain <= in_chain;
        end
    end

endmodule

// File: rtl/prefix_scan_pipe.sv
// rtl/prefix_scan_pipe.sv - pipelined parallel-prefix scan with operator select, exclusive mode and carry chaining
module prefix_scan_pipe
    import prefix_scan_pkg::*;
#(
    parameter int LANES = 8,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_valid,
    output logic               IN_ready,
    input  logic [LANES*W-1:0] IN_data,
    input  logic [1:0]         IN_mode,
    input  logic               IN_excl,
    input  logic               IN_chain,
    output logic               OUT_valid,
    input  logic               OUT_ready,
    output logic [LANES*W-1:0] OUT_data,
    output logic [W-1:0]       OUT_total
);

    localparam int L = $clog2(LANES);

    // Single stall domain: everything holds while the output beat is blocked.
    logic advance;
    assign advance  = !(OUT_valid && !OUT_ready);
    assign IN_ready = advance;

    logic               in_v;
    logic [LANES*W-1:0] in_d;
    logic [1:0]         in_m;
    logic               in_e;
    logic               in_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v <= 1'b0;
            in_d <= '0;
            in_m <= '0;
            in_e <= 1'b0;
            in_c <= 1'b0;
        end else if (advance) begin
            in_v <= IN_valid;
            in_d <= IN_data;
            in_m <= IN_mode;
            in_e <= IN_excl;
            in_c <= IN_chain;
        end
    end

    // Index 0 is the input register; index s is the output of combine level s.
    logic               st_valid [0:L];
    logic [LANES*W-1:0] st_data  [0:L];
    logic [1:0]         st_mode  [0:L];
    logic               st_excl  [0:L];
    logic               st_chain [0:L];

    assign st_valid[0] = in_v;
    assign st_data[0]  = in_d;
    assign st_mode[0]  = in_m;
    assign st_excl[0]  = in_e;
    assign st_chain[0] = in_c;

    for (genvar s = 1; s <= L; s++) begin : g_stage
        prefix_scan_stage #(
            .LANES (LANES),
            .W     (W),
            .DIST  (1 << (s - 1))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (st_valid[s-1]),
            .in_data   (st_data[s-1]),
            .in_mode   (st_mode[s-1]),
            .in_excl   (st_excl[s-1]),
            .in_chain  (st_chain[s-1]),
            .out_valid (st_valid[s]),
            .out_data  (st_data[s]),
            .out_mode  (st_mode[s]),
            .out_excl  (st_excl[s]),
            .out_chain (st_chain[s])
        );
    end

    function automatic logic [W-1:0] lane_op(
        input logic [1:0]   m,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        return W'(scan_combine(scan_op_e'(m), MAX_W'(a), MAX_W'(b)));
    endfunction

    logic [W-1:0]       carry;
    logic [W-1:0]       seed;
    logic [LANES*W-1:0] out_next;
    logic [W-1:0]       total_next;

    always_comb begin
        seed     = st_chain[L] ? carry : W'(IDENTITY);
        out_next = '0;
        // Exclusive shift moves each inclusive result up one lane; lane 0 gets the seed.
        out_next[0 +: W] = st_excl[L] ? seed
                                      : lane_op(st_mode[L], seed, st_data[L][0 +: W]);
        for (int i = 1; i < LANES; i++) begin
            if (st_excl[L])
                out_next[i*W +: W] = lane_op(st_mode[L], seed, st_data[L][(i-1)*W +: W]);
            else
                out_next[i*W +: W] = lane_op(st_mode[L], seed, st_data[L][i*W +: W]);
        end
        total_next = lane_op(st_mode[L], seed, st_data[L][(LANES-1)*W +: W]);
    end

    // The carry is taken as the beat enters the output register so the very
    // next beat behind it can chain without waiting for the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OUT_valid <= 1'b0;
            OUT_data  <= '0;
            OUT_total <= '0;
            carry     <= '0;
        end else if (advance) begin
            OUT_valid <= st_valid[L];
            if (st_valid[L]) begin
                OUT_data  <= out_next;
                OUT_total <= total_next;
                carry     <= total_next;
            end
        end
    end

endmodule

// File: tb/tb_prefix_scan_pipe.sv
// tb/tb_prefix_scan_pipe.sv - scoreboard bench for prefix_scan_pipe
module tb_prefix_scan_pipe;

    localparam int LANES = 8;
    localparam int W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             IN_valid;
    logic             IN_ready;
    logic [127:0]     IN_data;
    logic [1:0]       IN_mode;
    logic             IN_excl;
    logic             IN_chain;
    logic             OUT_valid;
    logic             OUT_ready;
    logic [127:0]     OUT_data;
    logic [15:0]      OUT_total;

    always #5 clk = ~clk;

    prefix_scan_pipe #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN_valid  (IN_valid),
        .IN_ready  (IN_ready),
        .IN_data   (IN_data),
        .IN_mode   (IN_mode),
        .IN_excl   (IN_excl),
        .IN_chain  (IN_chain),
        .OUT_valid (OUT_valid),
        .OUT_ready (OUT_ready),
        .OUT_data  (OUT_data),
        .OUT_total (OUT_total)
    );

    typedef struct {
        logic [127:0] d;
        logic [15:0]  t;
    } exp_t;

    exp_t         sb[$];
    exp_t         popped;
    int           checks = 0;
    int           errors = 0;
    logic         held = 1'b0;
    logic [127:0] held_d;
    logic [15:0]  held_t;

    function automatic logic [127:0] pk(input int v0, input int v1, input int v2, input int v3,
                                        input int v4, input int v5, input int v6, input int v7);
        return {16'(v7), 16'(v6), 16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    function automatic logic [127:0] seq(input int base, input int step);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(base + i * step);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [1:0] m, input logic e, input logic c,
                        input logic [127:0] ed, input logic [15:0] et);
        bit ok;
        ok = 1'b0;
        IN_data  = d;
        IN_mode  = m;
        IN_excl  = e;
        IN_chain = c;
        IN_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (IN_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got IN_ready=0 expected 1");
            IN_valid = 1'b0;
            return;
        end
        sb.push_back('{ed, et});
        @(posedge clk);
        #1;
        IN_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_pending", 128'(sb.size()), 128'(0));
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks that a
    // blocked output beat holds steady with the input side closed.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (OUT_valid) begin
            if (held) begin
                chk("hold_data", OUT_data, held_d);
                chk("hold_total", 128'(OUT_total), 128'(held_t));
            end
            if (OUT_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %h expected no beat", OUT_data);
                end else begin
                    popped = sb.pop_front();
                    chk("out_data", OUT_data, popped.d);
                    chk("out_total", 128'(OUT_total), 128'(popped.t));
                end
            end else begin
                chk("stall_in_ready", 128'(IN_ready), 128'(0));
                held   = 1'b1;
                held_d = OUT_data;
                held_t = OUT_total;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst       = 1'b1;
        IN_valid  = 1'b0;
        IN_data   = '0;
        IN_mode   = 2'd0;
        IN_excl   = 1'b0;
        IN_chain  = 1'b0;
        OUT_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(OUT_valid), 128'(0));
        chk("rst_out_data", OUT_data, 128'(0));
        chk("rst_out_total", 128'(OUT_total), 128'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(IN_ready), 128'(1));
        @(posedge clk);
        #1;

        // ADD inclusive, unchained, with first-beat latency
        send(pk(1,2,3,4,5,6,7,8), 2'd0, 1'b0, 1'b0, pk(1,3,6,10,15,21,28,36), 16'd36);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (OUT_valid) break;
        end
        chk("latency", 128'(lat), 128'(4));
        drain();

        // chained inclusive, then the same pair with an exclusive second beat
        send(seq(1,0), 2'd0, 1'b0, 1'b1, seq(37,1), 16'd44);
        send(pk(1,2,3,4,5,6,7,8), 2'd0, 1'b0, 1'b0, pk(1,3,6,10,15,21,28,36), 16'd36);
        send(seq(1,0), 2'd0, 1'b1, 1'b1, seq(36,1), 16'd44);
        drain();

        // MAXU, XOR, ADD wrap, then a chained operator switch
        send(pk(3,1,4,1,5,9,2,6), 2'd2, 1'b0, 1'b0, pk(3,3,4,4,5,9,9,9), 16'd9);
        send(seq(16'h00FF,0), 2'd3, 1'b0, 1'b0, pk(255,0,255,0,255,0,255,0), 16'h0000);
        send(seq(16'hFFFF,0), 2'd0, 1'b0, 1'b0, seq(16'hFFFF,-1), 16'hFFF8);
        send(pk(1,2,3,4,5,6,7,8), 2'd2, 1'b0, 1'b1, seq(16'hFFF8,0), 16'hFFF8);
        drain();

        // six back-to-back chained beats with a three-cycle output stall
        fork
            begin
                for (int n = 0; n < 100 && !OUT_valid; n++) @(negedge clk);
                @(posedge clk);
                #1;
                OUT_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                OUT_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 6; k++) begin
            if (k == 3)
                send(seq(1,0), 2'd0, 1'b1, 1'b1, seq(8*k,1), 16'(8*k+8));
            else
                send(seq(1,0), 2'd0, 1'b0, (k != 0), seq(8*k+1,1), 16'(8*k+8));
        end
        drain();
        #1;
        chk("stall_released", 128'(OUT_ready), 128'(1));

        // reset with beats in flight, then a chained beat sees a cleared carry
        send(seq(5,0), 2'd0, 1'b0, 1'b0, seq(5,5), 16'd40);
        send(seq(5,0), 2'd0, 1'b0, 1'b1, seq(45,5), 16'd80);
        send(seq(5,0), 2'd0, 1'b0, 1'b1, seq(85,5), 16'd120);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", 128'(OUT_valid), 128'(1));
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", 128'(OUT_valid), 128'(0));
        chk("midrst_out_data", OUT_data, 128'(0));
        chk("midrst_out_total", 128'(OUT_total), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            chk("post_rst_flushed", 128'(OUT_valid), 128'(0));
        end
        send(pk(1,2,3,4,5,6,7,8), 2'd0, 1'b0, 1'b1, pk(1,3,6,10,15,21,28,36), 16'd36);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
